// File: rtl/gtech_elastic_buf_if.sv
// Handshake bundle for gtech_elastic_buf: write side, read side and occupancy status.
// The master is the producer/consumer pair; the slave is the buffer itself.
interface gtech_elastic_buf_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
);
   logic [WIDTH-1:0] A;
   logic             A_VALID;
   logic             A_READY;
   logic [WIDTH-1:0] Z;
   logic             Z_VALID;
   logic             Z_READY;
   logic [CNT_W-1:0] COUNT;
   logic             FULL;
   logic             EMPTY;

   modport master (
      output A, A_VALID, Z_READY,
      input  A_READY, Z, Z_VALID, COUNT, FULL, EMPTY
   );

   modport slave (
      input  A, A_VALID, Z_READY,
      output A_READY, Z, Z_VALID, COUNT, FULL, EMPTY
   );
endinterface

// File: rtl/gtech_elastic_buf.sv
// Registered WIDTH x DEPTH elastic buffer with valid/ready on both sides.
// Z, Z_VALID, COUNT, FULL and EMPTY come straight from flops; A_READY is the only combinational output.
module gtech_elastic_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input logic              CLK,
   input logic              RST,
   gtech_elastic_buf_if.slave bus
);
   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (WIDTH < 1)) begin : g_bad_params
         $error("gtech_elastic_buf: DEPTH must be a power of 2 >= 2 and WIDTH >= 1");
      end
   endgenerate

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] z_r;
   logic             z_valid_r;
   logic             full_r;
   logic             empty_r;

   logic             a_ready_s;
   logic             push_s;
   logic             pop_s;
   logic [PTR_W-1:0] rd_next_ptr_s;
   logic [CNT_W-1:0] count_next_s;
   logic [WIDTH-1:0] head_next_s;

   // Handshake qualification and next occupancy.
   always_comb begin
      a_ready_s     = !full_r && !RST;
      push_s        = bus.A_VALID && a_ready_s;
      pop_s         = z_valid_r && bus.Z_READY;
      rd_next_ptr_s = rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // Next head value; the incoming word becomes the head when it lands in an
   // empty buffer or replaces the last entry being popped in the same cycle.
   always_comb begin
      head_next_s = z_r;
      if (count_next_s == CNT_ZERO) begin
         head_next_s = '0;
      end else if (count_r == CNT_ZERO) begin
         head_next_s = bus.A;
      end else if (pop_s) begin
         if (count_r == CNT_ONE) begin
            head_next_s = bus.A;
         end else begin
            head_next_s = mem_r[rd_next_ptr_s];
         end
      end else begin
         head_next_s = z_r;
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= bus.A;
      end
   end

   // Pointers, occupancy and registered head/status outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         z_r       <= '0;
         z_valid_r <= 1'b0;
         full_r    <= 1'b0;
         empty_r   <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_next_ptr_s;
         end
         count_r   <= count_next_s;
         z_r       <= head_next_s;
         z_valid_r <= (count_next_s != CNT_ZERO);
         full_r    <= (count_next_s == CNT_FULL);
         empty_r   <= (count_next_s == CNT_ZERO);
      end
   end

   assign bus.A_READY = a_ready_s;
   assign bus.Z       = z_r;
   assign bus.Z_VALID = z_valid_r;
   assign bus.COUNT   = count_r;
   assign bus.FULL    = full_r;
   assign bus.EMPTY   = empty_r;
endmodule

// File: tb/tb_gtech_elastic_buf.sv
// Directed and random checks of gtech_elastic_buf against a queue scoreboard.
// Instance a: WIDTH=8/DEPTH=4 directed tests; instance b: WIDTH=16/DEPTH=8 random backpressure.
module tb_gtech_elastic_buf;
   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_cmp;
   int   n_err;
   logic [7:0]  q_a [$];
   logic [15:0] q_b [$];

   gtech_elastic_buf_if #(.WIDTH(8),  .DEPTH(4)) bus_a ();
   gtech_elastic_buf_if #(.WIDTH(16), .DEPTH(8)) bus_b ();

   gtech_elastic_buf #(.WIDTH(8),  .DEPTH(4)) dut_a (.CLK(clk), .RST(rst_a), .bus(bus_a));
   gtech_elastic_buf #(.WIDTH(16), .DEPTH(8)) dut_b (.CLK(clk), .RST(rst_b), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of instance a: drive, check against model at negedge, update model.
   task automatic tick_a(input logic rst, input logic av, input logic [7:0] a, input logic zr);
      int  sz;
      logic do_push;
      rst_a = rst; bus_a.A_VALID = av; bus_a.A = a; bus_a.Z_READY = zr;
      @(negedge clk);
      sz = q_a.size();
      chk("a_ready", {31'd0, bus_a.A_READY}, {31'd0, (!rst && sz < 4)});
      chk("count",   {29'd0, bus_a.COUNT},   sz);
      chk("z_valid", {31'd0, bus_a.Z_VALID}, {31'd0, (sz != 0)});
      chk("empty",   {31'd0, bus_a.EMPTY},   {31'd0, (sz == 0)});
      chk("full",    {31'd0, bus_a.FULL},    {31'd0, (sz == 4)});
      chk("z_head",  {24'd0, bus_a.Z},       {24'd0, (sz != 0) ? q_a[0] : 8'h00});
      if (rst) begin
         q_a.delete();
      end else begin
         do_push = av && (sz < 4);
         if (zr && sz != 0) void'(q_a.pop_front());
         if (do_push) q_a.push_back(a);
      end
      @(posedge clk); #1;
   endtask

   task automatic tick_b(input logic av, input logic [15:0] a, input logic zr);
      int  sz;
      logic do_push;
      rst_b = 1'b0; bus_b.A_VALID = av; bus_b.A = a; bus_b.Z_READY = zr;
      @(negedge clk);
      sz = q_b.size();
      chk("b_a_ready", {31'd0, bus_b.A_READY}, {31'd0, (sz < 8)});
      chk("b_count",   {28'd0, bus_b.COUNT},   sz);
      chk("b_full_empty", {31'd0, (bus_b.FULL && bus_b.EMPTY)}, 32'd0);
      chk("b_z_head",  {16'd0, bus_b.Z},       {16'd0, (sz != 0) ? q_b[0] : 16'h0000});
      do_push = av && (sz < 8);
      if (zr && sz != 0) void'(q_b.pop_front());
      if (do_push) q_b.push_back(a);
      @(posedge clk); #1;
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_a = 1'b1; bus_a.A_VALID = 1'b1; bus_a.A = 8'hAA; bus_a.Z_READY = 1'b0;
      rst_b = 1'b1; bus_b.A_VALID = 1'b0; bus_b.A = 16'h0000; bus_b.Z_READY = 1'b0;
      @(posedge clk); #1;

      // Reset held three cycles with a pending write
      for (int i = 0; i < 3; i++) tick_a(1'b1, 1'b1, 8'hAA, 1'b0);
      tick_a(1'b0, 1'b1, 8'hAA, 1'b0);
      tick_a(1'b0, 1'b0, 8'h00, 1'b1);
      chk("aa_drained", q_a.size(), 32'd0);

      // Fill, refused fifth push, drain
      for (int i = 1; i <= 4; i++) tick_a(1'b0, 1'b1, 8'(i), 1'b0);
      tick_a(1'b0, 1'b1, 8'h05, 1'b0);
      chk("fill_q", q_a.size(), 32'd4);
      for (int i = 0; i < 5; i++) tick_a(1'b0, 1'b0, 8'h00, 1'b1);

      // Streaming 0..31 with continuous ready
      for (int i = 0; i < 32; i++) tick_a(1'b0, 1'b1, 8'(i), 1'b1);
      tick_a(1'b0, 1'b0, 8'h00, 1'b1);
      tick_a(1'b0, 1'b0, 8'h00, 1'b0);

      // Full with simultaneous pop: push refused, accepted next cycle
      for (int i = 0; i < 4; i++) tick_a(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
      tick_a(1'b0, 1'b1, 8'h50, 1'b1);
      chk("full_pop_q", q_a.size(), 32'd3);
      tick_a(1'b0, 1'b1, 8'h50, 1'b0);
      chk("full_refill_q", q_a.size(), 32'd4);
      for (int i = 0; i < 4; i++) tick_a(1'b0, 1'b0, 8'h00, 1'b1);
      tick_a(1'b0, 1'b0, 8'h00, 1'b1);

      // Mid-operation reset discards 10/11/12
      tick_a(1'b0, 1'b1, 8'h10, 1'b0);
      tick_a(1'b0, 1'b1, 8'h11, 1'b0);
      tick_a(1'b0, 1'b1, 8'h12, 1'b0);
      tick_a(1'b1, 1'b0, 8'h00, 1'b1);
      tick_a(1'b0, 1'b1, 8'h55, 1'b0);
      tick_a(1'b0, 1'b0, 8'h00, 1'b1);
      tick_a(1'b0, 1'b0, 8'h00, 1'b0);

      // Random backpressure on the wider, deeper instance
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++)
         tick_b(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 9; i++) tick_b(1'b0, 16'h0000, 1'b1);
      chk("b_drained", q_b.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
